// File: rtl/sdram_buf_drain.sv
// rtl/sdram_buf_drain.sv - drains one line-buffer line into a byte-masked SDRAM write burst
module sdram_buf_drain #(
    parameter int ADDR_WIDTH      = 3,
    parameter int LINE_ADDR_WIDTH = 21
) (
    input  logic                          sdram_clk,
    input  logic                          sdram_rst,
    input  logic                          start_i,
    input  logic [LINE_ADDR_WIDTH-1:0]    line_adr_i,
    input  logic [4*(1<<ADDR_WIDTH)-1:0]  dirty_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [ADDR_WIDTH-1:0]         buf_adr_o,
    input  logic [31:0]                   buf_dat_i,
    output logic                          wr_req_o,
    output logic [LINE_ADDR_WIDTH-1:0]    wr_adr_o,
    input  logic                          wr_ack_i,
    output logic                          wr_valid_o,
    input  logic                          wr_ready_i,
    output logic [31:0]                   wr_dat_o,
    output logic [3:0]                    wr_dqm_o
);
    localparam int BL = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_idx;
    logic [4*BL-1:0]              r_dirty;
    logic [LINE_ADDR_WIDTH-1:0]   r_line_adr;

    logic                         w_last;
    logic                         w_accept;
    logic [ADDR_WIDTH-1:0]        w_buf_adr;

    assign w_last   = (r_idx == ADDR_WIDTH'(BL - 1));
    assign w_accept = (r_state == S_STREAM) && wr_ready_i;

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_dirty    <= '0;
            r_line_adr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_line_adr <= line_adr_i;
                        r_dirty    <= dirty_i;
                        r_idx      <= '0;
                        // A clean line never opens a burst.
                        r_state    <= (dirty_i == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (wr_ack_i) begin
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During a stall the current word is re-read so the buffer output holds steady.
    always_comb begin
        w_buf_adr = '0;
        if (r_state == S_STREAM) begin
            w_buf_adr = (w_accept && !w_last) ? (r_idx + ADDR_WIDTH'(1)) : r_idx;
        end
    end

    assign buf_adr_o  = w_buf_adr;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign wr_req_o   = (r_state == S_REQ);
    assign wr_valid_o = (r_state == S_STREAM);
    assign wr_adr_o   = r_line_adr;
    assign wr_dat_o   = buf_dat_i;
    assign wr_dqm_o   = wr_valid_o ? ~r_dirty[4*r_idx +: 4] : 4'h0;

endmodule

// File: tb/tb_sdram_buf_drain.sv
// tb/tb_sdram_buf_drain.sv - directed table-driven bench for sdram_buf_drain
module tb_sdram_buf_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [20:0] line_adr_i = '0;
    logic [31:0] dirty_i = '0;
    logic        busy_o, done_o, wr_req_o, wr_valid_o;
    logic [2:0]  buf_adr_o;
    logic [31:0] buf_dat_i;
    logic [20:0] wr_adr_o;
    logic        wr_ack_i = 1'b0;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_dat_o;
    logic [3:0]  wr_dqm_o;

    int n_vec = 0;
    int n_err = 0;

    sdram_buf_drain #(.ADDR_WIDTH(3), .LINE_ADDR_WIDTH(21)) dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .start_i   (start_i),
        .line_adr_i(line_adr_i),
        .dirty_i   (dirty_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .buf_adr_o (buf_adr_o),
        .buf_dat_i (buf_dat_i),
        .wr_req_o  (wr_req_o),
        .wr_adr_o  (wr_adr_o),
        .wr_ack_i  (wr_ack_i),
        .wr_valid_o(wr_valid_o),
        .wr_ready_i(wr_ready_i),
        .wr_dat_o  (wr_dat_o),
        .wr_dqm_o  (wr_dqm_o)
    );

    always #5 clk = ~clk;

    // Registered-read line buffer holding A000_0000 + w.
    always @(posedge clk) buf_dat_i <= 32'hA000_0000 + {29'd0, buf_adr_o};

    typedef struct {
        logic [31:0] dirty;
        logic [20:0] ladr;
        int          ack_delay;
        logic [3:0]  rdy_pat;
        bit          sticky;
        logic [31:0] exp_dqm;
        int          exp_req;
        int          exp_words;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_drain(input vec_t v, input bit hold);
        int cyc, req_cnt, nacc, ack_cyc, first_v, done_cyc, last_acc, done_cnt, sidx;
        bit prev_stall, fin, skip_bad;
        logic [31:0] pd;
        logic [3:0] pq;
        start_i = 1'b1; line_adr_i = v.ladr; dirty_i = v.dirty;
        wr_ack_i = 1'b0; wr_ready_i = 1'b0;
        @(posedge clk);
        cyc = 0; req_cnt = 0; nacc = 0; ack_cyc = -1; first_v = -1; done_cyc = -1;
        last_acc = -1; done_cnt = 0; sidx = 0; prev_stall = 0; fin = 0; skip_bad = 0;
        pd = '0; pq = '0;
        while (!fin && cyc < 300) begin
            cyc++;
            #2;
            if (!hold) start_i = 1'b0;
            wr_ack_i = 1'b0;
            if (wr_req_o) begin
                req_cnt++;
                if (req_cnt >= v.ack_delay && ack_cyc < 0) begin
                    wr_ack_i = 1'b1;
                    ack_cyc = cyc;
                end
            end
            if (v.sticky && ack_cyc >= 0) wr_ack_i = 1'b1;
            wr_ready_i = v.rdy_pat[sidx % 4];
            if (wr_valid_o) sidx++;
            #1;
            if (wr_req_o || wr_valid_o || buf_adr_o != 3'd0) skip_bad = 1;
            if (wr_valid_o) begin
                if (first_v < 0) first_v = cyc;
                if (prev_stall) chk("stall_hold", {wr_dat_o, wr_dqm_o}, {pd, pq});
                if (wr_ready_i) begin
                    if (nacc < 8) begin
                        chk("word_dat", wr_dat_o, 32'hA000_0000 + nacc);
                        chk("word_dqm", wr_dqm_o, v.exp_dqm[4*nacc +: 4]);
                        chk("wr_adr", wr_adr_o, v.ladr);
                    end
                    nacc++;
                    last_acc = cyc;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    pd = wr_dat_o;
                    pq = wr_dqm_o;
                end
            end else if (prev_stall) begin
                chk("stall_valid", 1'b0, 1'b1);
                prev_stall = 0;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("idle_after_done", busy_o, 1'b0);
                fin = 1;
            end
            if (!fin) @(posedge clk);
        end
        chk("drain_timeout", fin, 1'b1);
        chk("req_cycles", req_cnt, v.exp_req);
        chk("word_count", nacc, v.exp_words);
        chk("done_count", done_cnt, 1);
        if (v.exp_words == 0) begin
            chk("skip_done_cycle", done_cyc, 1);
            chk("skip_quiet", skip_bad, 1'b0);
        end else begin
            chk("done_latency", done_cyc, last_acc + 1);
            chk("first_valid", first_v, ack_cyc + 2);
        end
    endtask

    initial begin
        int acc;
        vecs[0] = '{32'hFFFF_FFFF, 21'h1_2345, 3, 4'b1111, 1'b0, 32'h0000_0000, 3, 8};
        vecs[1] = '{32'hFFFF_FFFF, 21'h1_2345, 3, 4'b1001, 1'b0, 32'h0000_0000, 3, 8};
        vecs[2] = '{32'h0000_0000, 21'h0_ABCD, 3, 4'b1111, 1'b0, 32'h0000_0000, 0, 0};
        vecs[3] = '{32'h8000_00F0, 21'h1_2345, 2, 4'b1111, 1'b0, 32'h7FFF_FF0F, 2, 8};
        vecs[4] = '{32'h0F0F_00FF, 21'h1F_FFFF, 1, 4'b0110, 1'b1, 32'hF0F0_FF00, 1, 8};

        #1;
        chk("rst_outputs", {busy_o, done_o, wr_req_o, wr_valid_o, buf_adr_o, wr_adr_o, wr_dqm_o}, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        for (int i = 0; i < 5; i++) begin
            run_drain(vecs[i], 1'b0);
            @(posedge clk); #2;
        end

        // Reset after word 3 is accepted aborts the drain.
        start_i = 1'b1; line_adr_i = 21'h0_5555; dirty_i = 32'hFFFF_FFFF;
        wr_ack_i = 1'b1; wr_ready_i = 1'b1;
        acc = 0;
        for (int c = 0; c < 50 && acc < 4; c++) begin
            @(posedge clk); #2;
            start_i = 1'b0;
            #1;
            if (wr_valid_o && wr_ready_i) acc++;
        end
        chk("pre_reset_words", acc, 4);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {busy_o, done_o, wr_req_o, wr_valid_o, buf_adr_o, wr_adr_o, wr_dqm_o}, '0);
        @(posedge clk); #1;
        chk("mid_rst_no_done", done_o, 1'b0);
        wr_ack_i = 1'b0; wr_ready_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy_o, done_o}, 2'b00);
        #1;
        run_drain(vecs[0], 1'b0);
        @(posedge clk); #2;

        // start_i held high: a second drain starts only from the IDLE cycle after done_o.
        run_drain(vecs[3], 1'b1);
        @(posedge clk); #3;
        chk("restart_busy", {busy_o, wr_req_o}, 2'b11);
        start_i = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_buf_drain.md
# sdram_buf_drain

Drains one line from the SDRAM controller's dual-port line buffer and presents it as a byte-masked write burst to the SDRAM command/data path. It sits on the SDRAM-clock side of the line buffer and reads that buffer's port B while the bus side owns port A. It captures a line address and a per-byte dirty mask, and it never opens a burst for a clean line. It then streams one word per cycle under valid/ready flow control.

## Interface
- ADDR_WIDTH, 3, buffer word-address width; burst length BL = 2^ADDR_WIDTH words of 32 bits
- LINE_ADDR_WIDTH, 21, width of the SDRAM line address passed through to the controller

- sdram_clk  in  1  sole clock, rising edge
- sdram_rst  in  1  reset, asynchronous, active-high
- start_i  in  1  request to drain the buffer; sampled only in IDLE
- line_adr_i  in  LINE_ADDR_WIDTH  line address, captured with start_i
- dirty_i  in  4*BL  byte-dirty mask, bit 4*w+b = byte b of word w; captured with start_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the drain is finished
- buf_adr_o  out  ADDR_WIDTH  buffer read address; the buffer registers it, so data returns next cycle
- buf_dat_i  in  32  buffer read data for the address presented on the previous edge
- wr_req_o  out  1  burst-open request to the SDRAM controller
- wr_adr_o  out  LINE_ADDR_WIDTH  captured line address; stable while busy_o is high
- wr_ack_i  in  1  controller has accepted the burst request
- wr_valid_o  out  1  wr_dat_o/wr_dqm_o hold a valid word
- wr_ready_i  in  1  controller accepts the word this cycle
- wr_dat_o  out  32  burst data, equal to buf_dat_i
- wr_dqm_o  out  4  byte mask, active-high = do not write; equal to ~dirty_q[4*idx +: 4]

## Operation
- Registers:
  - state
  - idx (ADDR_WIDTH bits, word index)
  - dirty_q
  - wr_adr_o
- States: IDLE, REQ, PRIME, STREAM, DONE.
- IDLE:
  - On start_i, capture line_adr_i and dirty_i, and set idx to 0.
  - If dirty_i == 0, go to DONE (skip; no request is issued).
  - Otherwise go to REQ.
- REQ: wr_req_o = 1. When wr_ack_i is sampled high, go to PRIME. wr_req_o is combinational from state, so it is low from the next cycle.
- PRIME: buf_adr_o = 0. This is one read-latency cycle, and the next state is always STREAM.
- STREAM:
  - wr_valid_o = 1.
  - A word is accepted on an edge where wr_valid_o and wr_ready_i are both high.
  - buf_adr_o = idx + 1 while accepting and idx < BL-1. Otherwise buf_adr_o = idx, which re-reads the current word during a stall so wr_dat_o stays stable.
  - On acceptance, idx increments.
  - On acceptance with idx == BL-1, go to DONE. idx does not wrap within a burst.
- DONE: done_o = 1 and busy_o = 1 for this one cycle, then go to IDLE.
- start_i is ignored in every state except IDLE; it is not queued.
- The buffer must not be written through port A while busy_o is high. The bus side gates on busy_o.
- Words with an all-clean mask are still streamed with wr_dqm_o = 4'hF. The burst length is always BL.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE, and idx, dirty_q and wr_adr_o go to 0.
  - All outputs are 0: busy_o, done_o, wr_req_o, wr_valid_o, buf_adr_o, wr_adr_o, wr_dqm_o.
  - wr_dat_o follows buf_dat_i and is don't-care while wr_valid_o is 0.
- Reset mid-burst aborts the drain with no done_o pulse. The controller sees wr_valid_o drop immediately.
- start_i sampled at edge 0: busy_o and wr_req_o are high from cycle 1.
- wr_ack_i sampled at edge k: PRIME is cycle k+1 and the first wr_valid_o is cycle k+2.
- With wr_ready_i held high:
  - Words 0..BL-1 are presented in cycles k+2..k+BL+1, one per cycle, with no bubbles.
  - done_o is in cycle k+BL+2.
  - IDLE is reached in cycle k+BL+3, when a new start_i is accepted.
- Skip path: start_i at edge 0 gives done_o in cycle 1 and IDLE in cycle 2. wr_req_o and wr_valid_o are never asserted.
- wr_ready_i low stalls STREAM indefinitely. wr_valid_o, wr_dat_o and wr_dqm_o stay unchanged during the stall.
- wr_ack_i outside REQ is ignored.

## Test plan
- Full drain: BL=8, buffer word w = 32'hA000_0000+w, dirty all ones, line_adr 21'h1_2345, ack after 3 cycles, ready held 1 → wr_req_o is high for 3 cycles. Words A0000000..A0000007 appear on consecutive cycles with dqm 0 and wr_adr_o 1_2345. Exactly one done_o follows the last word.
- Backpressure: same setup with wr_ready_i toggling 1,0,0,1,… → every word is delivered exactly once, in order. Data and dqm are stable through each stall, and done_o comes one cycle after word 7 is accepted.
- Clean-line skip: dirty_i = 0 → done_o is in cycle 1. wr_req_o, wr_valid_o and buf_adr_o stay 0.
- Partial mask: dirty = 32'h0000_00F0 plus word 7 byte 3 set → word 1 has dqm 0; word 7 has dqm 4'h7; all other words have dqm 4'hF. The burst length is still 8.
- Reset mid-stream: assert sdram_rst after word 3 is accepted → all outputs are 0 immediately and there is no done_o. A following start_i runs a complete correct drain from word 0.
- start_i held high throughout a drain → it is ignored while busy. A second drain begins only on the first IDLE cycle after done_o.
